// File: rtl/sdram_if_pkg.sv
// Shared constants and state encoding for the SDRAM bridge masters (reader and writer).
package sdram_if_pkg;

  localparam int unsigned INTERFACE_WIDTH_BITS = 128;
  localparam int unsigned INTERFACE_ADDR_BITS  = 26;
  localparam int unsigned WORD_BITS            = 32;
  localparam int unsigned WORDS_PER_LINE       = INTERFACE_WIDTH_BITS / WORD_BITS;
  localparam int unsigned LINE_BYTES           = INTERFACE_WIDTH_BITS / 8;
  localparam int unsigned COUNT_BITS           = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } writer_state_t;

endpackage

// File: rtl/sdram_writer_line_packer.sv
// Packs accepted words into a line; flags the line complete on the last lane or on in_last.
module sdram_writer_line_packer #(
  parameter int unsigned WORD_BITS      = sdram_if_pkg::WORD_BITS,
  parameter int unsigned WORDS_PER_LINE = sdram_if_pkg::WORDS_PER_LINE
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  clear,
  input  logic                                  accept,
  input  logic [WORD_BITS-1:0]                  in_data,
  input  logic                                  in_last,
  output logic [WORD_BITS*WORDS_PER_LINE-1:0]   line_data_c,
  output logic [WORD_BITS*WORDS_PER_LINE/8-1:0] line_be_c,
  output logic                                  line_complete_c
);

  localparam int unsigned LINE_BITS = WORD_BITS * WORDS_PER_LINE;
  localparam int unsigned BPW       = WORD_BITS / 8;
  localparam int unsigned IDX_W     = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;

  logic [LINE_BITS-1:0]   pack_q;
  logic [LINE_BITS/8-1:0] be_q;
  logic [IDX_W-1:0]       idx_q;

  // Merge the presented word into its lane; the result is the line as it stands after this accept.
  always_comb begin
    line_data_c = pack_q;
    line_be_c   = be_q;
    for (int unsigned k = 0; k < WORDS_PER_LINE; k++) begin
      if (idx_q == IDX_W'(k)) begin
        line_data_c[k*WORD_BITS +: WORD_BITS] = in_data;
        line_be_c[k*BPW +: BPW]               = '1;
      end
    end
    line_complete_c = accept && ((idx_q == IDX_W'(WORDS_PER_LINE - 1)) || in_last);
  end

  // Accumulate words; an emptied buffer guarantees zeroed lanes on a partial flush.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pack_q <= '0;
      be_q   <= '0;
      idx_q  <= '0;
    end else if (clear || line_complete_c) begin
      pack_q <= '0;
      be_q   <= '0;
      idx_q  <= '0;
    end else if (accept) begin
      pack_q <= line_data_c;
      be_q   <= line_be_c;
      idx_q  <= idx_q + IDX_W'(1);
    end
  end

endmodule

// File: rtl/sdram_writer.sv
// Write-side bridge master: packs a word stream into lines and writes them at consecutive addresses.
// Optional build macro SDRAM_WRITER_PERF_EN adds stall_cycles / max_latency counters.
module sdram_writer #(
  parameter int unsigned INTERFACE_WIDTH_BITS = sdram_if_pkg::INTERFACE_WIDTH_BITS,
  parameter int unsigned INTERFACE_ADDR_BITS  = sdram_if_pkg::INTERFACE_ADDR_BITS,
  parameter int unsigned WORD_BITS            = sdram_if_pkg::WORD_BITS,
  parameter int unsigned COUNT_BITS           = sdram_if_pkg::COUNT_BITS
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              start,
  input  logic [INTERFACE_ADDR_BITS-1:0]    base_address,
  input  logic                              in_valid,
  input  logic [WORD_BITS-1:0]              in_data,
  input  logic                              in_last,
  output logic                              in_ready,
  output logic [INTERFACE_ADDR_BITS-1:0]    interface_address,
  output logic [INTERFACE_WIDTH_BITS/8-1:0] interface_byte_enable,
  output logic                              interface_write,
  output logic [INTERFACE_WIDTH_BITS-1:0]   interface_write_data,
  input  logic                              interface_acknowledge,
  output logic                              busy,
  output logic                              done,
  output logic [COUNT_BITS-1:0]             lines_written
`ifdef SDRAM_WRITER_PERF_EN
  ,
  output logic [31:0]                       stall_cycles,
  output logic [15:0]                       max_latency
`endif
);

  import sdram_if_pkg::writer_state_t;
  import sdram_if_pkg::IDLE;
  import sdram_if_pkg::FILL;
  import sdram_if_pkg::WRITE;
  import sdram_if_pkg::DONE;

  localparam int unsigned WORDS_PER_LINE = INTERFACE_WIDTH_BITS / WORD_BITS;
  localparam int unsigned LINE_BYTES     = INTERFACE_WIDTH_BITS / 8;

  writer_state_t                   state_q, state_d;
  logic                            start_c, launch_c, ack_c, accept_c;
  logic                            last_line_q;
  logic [INTERFACE_WIDTH_BITS-1:0] line_data_c;
  logic [LINE_BYTES-1:0]           line_be_c;
  logic                            line_complete_c;
  logic [INTERFACE_ADDR_BITS-1:0]  base_aligned_c;

  assign accept_c       = in_valid && in_ready;
  assign base_aligned_c = base_address & ~INTERFACE_ADDR_BITS'(LINE_BYTES - 1);

  sdram_writer_line_packer #(
    .WORD_BITS      (WORD_BITS),
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) u_packer (
    .clk             (clk),
    .reset_n         (reset_n),
    .clear           (start_c),
    .accept          (accept_c),
    .in_data         (in_data),
    .in_last         (in_last),
    .line_data_c     (line_data_c),
    .line_be_c       (line_be_c),
    .line_complete_c (line_complete_c)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic and single-cycle event strobes.
  always_comb begin
    state_d  = state_q;
    start_c  = 1'b0;
    launch_c = 1'b0;
    ack_c    = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        start_c = 1'b1;
        state_d = FILL;
      end
      FILL: if (line_complete_c) begin
        launch_c = 1'b1;
        state_d  = WRITE;
      end
      WRITE: if (interface_acknowledge) begin
        ack_c   = 1'b1;
        state_d = last_line_q ? DONE : FILL;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs, bridge request payload, address stepping and line counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_ready              <= 1'b0;
      interface_write       <= 1'b0;
      busy                  <= 1'b0;
      done                  <= 1'b0;
      interface_address     <= '0;
      interface_byte_enable <= '0;
      interface_write_data  <= '0;
      lines_written         <= '0;
      last_line_q           <= 1'b0;
    end else begin
      in_ready        <= (state_d == FILL);
      interface_write <= (state_d == WRITE);
      busy            <= (state_d != IDLE);
      done            <= (state_d == DONE);
      if (start_c) begin
        interface_address <= base_aligned_c;
        lines_written     <= '0;
      end
      if (launch_c) begin
        interface_write_data  <= line_data_c;
        interface_byte_enable <= line_be_c;
        last_line_q           <= in_last;
      end
      if (ack_c) begin
        interface_address <= interface_address + INTERFACE_ADDR_BITS'(LINE_BYTES);
        if (lines_written != '1) lines_written <= lines_written + COUNT_BITS'(1);
      end
    end
  end

`ifdef SDRAM_WRITER_PERF_EN
  logic [15:0] wait_q;

  // Acknowledge-wait statistics for the current frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= '0;
      max_latency  <= '0;
      wait_q       <= '0;
    end else if (start_c) begin
      stall_cycles <= '0;
      max_latency  <= '0;
      wait_q       <= '0;
    end else if (state_q == WRITE) begin
      if (!interface_acknowledge) begin
        if (stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
        if (wait_q != '1)       wait_q       <= wait_q + 16'd1;
      end else begin
        if (wait_q > max_latency) max_latency <= wait_q;
        wait_q <= '0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sdram_writer.sv
// Directed bench for sdram_writer: frame table plus reset-abort sequence.
module tb_sdram_writer;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [25:0]  base_address;
  logic         in_valid;
  logic [31:0]  in_data;
  logic         in_last;
  logic         in_ready;
  logic [25:0]  interface_address;
  logic [15:0]  interface_byte_enable;
  logic         interface_write;
  logic [127:0] interface_write_data;
  logic         interface_acknowledge;
  logic         busy;
  logic         done;
  logic [15:0]  lines_written;
`ifdef SDRAM_WRITER_PERF_EN
  logic [31:0]  stall_cycles;
  logic [15:0]  max_latency;
`endif

  sdram_writer dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .start                 (start),
    .base_address          (base_address),
    .in_valid              (in_valid),
    .in_data               (in_data),
    .in_last               (in_last),
    .in_ready              (in_ready),
    .interface_address     (interface_address),
    .interface_byte_enable (interface_byte_enable),
    .interface_write       (interface_write),
    .interface_write_data  (interface_write_data),
    .interface_acknowledge (interface_acknowledge),
    .busy                  (busy),
    .done                  (done),
    .lines_written         (lines_written)
`ifdef SDRAM_WRITER_PERF_EN
    ,
    .stall_cycles          (stall_cycles),
    .max_latency           (max_latency)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [25:0]  base;
    int           n;
    logic [31:0]  first;
    int           ack_wait;
    int           glitch;
    int           exp_lines;
    logic [25:0]  exp_last_addr;
    logic [15:0]  exp_last_be;
    logic [127:0] exp_last_data;
  } vec_t;

  typedef struct {
    logic [25:0]  addr;
    logic [127:0] data;
    logic [15:0]  be;
  } wr_t;

  int   total = 0;
  int   bad   = 0;
  int   ack_wait = 0;
  int   done_cnt = 0;
  wr_t  wq[$];
  vec_t vecs[7];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] m_data(input logic [31:0] first, input int n, input int k);
    logic [127:0] d;
    d = '0;
    for (int j = 0; j < 4; j++)
      if (4*k + j < n) d[j*32 +: 32] = first + 32'(4*k + j);
    return d;
  endfunction

  function automatic logic [15:0] m_be(input int n, input int k);
    logic [15:0] b;
    b = '0;
    for (int j = 0; j < 4; j++)
      if (4*k + j < n) b[j*4 +: 4] = 4'hF;
    return b;
  endfunction

  function automatic logic [25:0] m_addr(input logic [25:0] base, input int k);
    return (base & 26'h3FFFFF0) + 26'(16*k);
  endfunction

  // Count done pulses.
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // Bridge responder: acknowledges after ack_wait cycles, checks the request holds steady.
  initial begin
    interface_acknowledge = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && interface_write === 1'b1) begin
        wr_t  cap;
        logic stable;
        logic aborted;
        cap.addr = interface_address;
        cap.data = interface_write_data;
        cap.be   = interface_byte_enable;
        stable   = 1'b1;
        aborted  = 1'b0;
        for (int i = 0; i < ack_wait; i++) begin
          @(negedge clk);
          if (reset_n !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          if (interface_write !== 1'b1 || interface_address !== cap.addr ||
              interface_write_data !== cap.data || interface_byte_enable !== cap.be ||
              in_ready !== 1'b0)
            stable = 1'b0;
        end
        if (!aborted) begin
          interface_acknowledge = 1'b1;
          @(negedge clk);
          interface_acknowledge = 1'b0;
          chk("write_drop_after_ack", interface_write, 0);
          chk("request_stable", stable, 1);
          wq.push_back(cap);
        end
      end
    end
  end

  task automatic feed_words(input int n, input logic [31:0] first, input int glitch);
    for (int i = 0; i < n; i++) begin
      int guard;
      in_valid = 1'b1;
      in_data  = first + 32'(i);
      in_last  = (i == n - 1);
      if (i == glitch) begin
        start        = 1'b1;
        base_address = 26'h0000500;
      end
      guard = 0;
      while (in_ready !== 1'b1 && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 200) begin
        total++;
        bad++;
        $display("FAIL feed_timeout: word %0d never accepted", i);
        break;
      end
      @(negedge clk);
      start = 1'b0;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    int   dc0;
    int   guard;
    logic seen;
    ack_wait = v.ack_wait;
    wq.delete();
    dc0 = done_cnt;
    @(negedge clk);
    start        = 1'b1;
    base_address = v.base;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_after_start"}, busy, 1);
    feed_words(v.n, v.first, v.glitch);
    seen  = 1'b0;
    guard = 0;
    while (guard < 400) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      guard++;
    end
    chk({tag, "_done_seen"}, seen, 1);
    @(negedge clk);
    chk({tag, "_busy_low"}, busy, 0);
    chk({tag, "_done_once"}, done_cnt - dc0, 1);
    chk({tag, "_lines_written"}, lines_written, v.exp_lines);
    chk({tag, "_n_writes"}, wq.size(), v.exp_lines);
    for (int k = 0; k < wq.size() && k < v.exp_lines; k++) begin
      chk({tag, "_addr"}, wq[k].addr, m_addr(v.base, k));
      chk({tag, "_data"}, wq[k].data, m_data(v.first, v.n, k));
      chk({tag, "_be"},   wq[k].be,   m_be(v.n, k));
    end
    if (wq.size() > 0) begin
      chk({tag, "_last_addr"}, wq[wq.size()-1].addr, v.exp_last_addr);
      chk({tag, "_last_be"},   wq[wq.size()-1].be,   v.exp_last_be);
      chk({tag, "_last_data"}, wq[wq.size()-1].data, v.exp_last_data);
    end
  endtask

  initial begin
    vec_t v;
    reset_n      = 1'b0;
    start        = 1'b0;
    base_address = '0;
    in_valid     = 1'b0;
    in_data      = '0;
    in_last      = 1'b0;

    //         base         n  first     wait glitch lines last_addr    be        last_data
    vecs[0] = '{26'h0000100, 8, 32'h01,  1,   -1,    2,    26'h0000110, 16'hFFFF, {32'h8, 32'h7, 32'h6, 32'h5}};
    vecs[1] = '{26'h0000200, 6, 32'h01,  0,   -1,    2,    26'h0000210, 16'h00FF, {32'h0, 32'h0, 32'h6, 32'h5}};
    vecs[2] = '{26'h3FFFFF0, 8, 32'h11,  0,   -1,    2,    26'h0000000, 16'hFFFF, {32'h18, 32'h17, 32'h16, 32'h15}};
    vecs[3] = '{26'h0000305, 1, 32'h0A,  2,   -1,    1,    26'h0000300, 16'h000F, {32'h0, 32'h0, 32'h0, 32'hA}};
    vecs[4] = '{26'h0000400, 4, 32'h21,  20,  -1,    1,    26'h0000400, 16'hFFFF, {32'h24, 32'h23, 32'h22, 32'h21}};
    vecs[5] = '{26'h0001000, 3, 32'hB0,  0,   -1,    1,    26'h0001000, 16'h0FFF, {32'h0, 32'hB2, 32'hB1, 32'hB0}};
    vecs[6] = '{26'h0000600, 8, 32'h31,  0,   2,     2,    26'h0000610, 16'hFFFF, {32'h38, 32'h37, 32'h36, 32'h35}};

    #3;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_write", interface_write, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_lines", lines_written, 0);
    chk("rst_addr", interface_address, 0);
    chk("rst_be", interface_byte_enable, 0);
    chk("rst_data", interface_write_data, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i], $sformatf("v%0d", i));
`ifdef SDRAM_WRITER_PERF_EN
      if (i == 4) begin
        chk("perf_stall", stall_cycles, 20);
        chk("perf_max_latency", max_latency, 20);
      end
`endif
    end

    // Reset while a write is outstanding: request must vanish immediately.
    ack_wait = 30;
    wq.delete();
    @(negedge clk);
    start        = 1'b1;
    base_address = 26'h0000700;
    @(negedge clk);
    start = 1'b0;
    feed_words(4, 32'h41, -1);
    chk("abort_write_up", interface_write, 1);
    repeat (3) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort_write_drop", interface_write, 0);
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_lines", lines_written, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    chk("abort_no_ack_logged", wq.size(), 0);

    v = '{26'h0000800, 4, 32'h51, 0, -1, 1, 26'h0000800, 16'hFFFF, {32'h54, 32'h53, 32'h52, 32'h51}};
    run_frame(v, "post_abort");

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
